mem_arbiter_rr: RTL and testbench

Parametrised round-robin memory arbiter. It multiplexes NUM_CLIENTS line-granular read/write requesters (fetch, load/store, and later prefetch and page walker) onto the single system bus. Compared with the single-client fetch-only arbiter, it adds:

- N-way fair arbitration;
- write-line support;
- per-client tags on the bus;
- response-tag checking;
- configurable data width and line size.

It sits between the core-side clients and the Sysbus pins.

---
 rtl/mem_arbiter_rr_if.sv | 25 ++
 rtl/mem_arbiter_rr.sv | 195 +++++++++++++++++++
 tb/tb_mem_arbiter_rr.sv | 276 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_rr_if.sv
// Sysbus channel between the arbiter (master) and memory (slave).
// Request words go out with a tag; response beats come back tagged.
interface mem_arbiter_rr_if #(
  parameter int DATA_WIDTH = 64,
  parameter int TAG_WIDTH  = 13
);
  logic                  reqcyc;
  logic                  reqack;
  logic [DATA_WIDTH-1:0] req;
  logic [TAG_WIDTH-1:0]  reqtag;
  logic                  respcyc;
  logic                  respack;
  logic [DATA_WIDTH-1:0] resp;
  logic [TAG_WIDTH-1:0]  resptag;

  modport master (
    output reqcyc, req, reqtag, respack,
    input  reqack, respcyc, resp, resptag
  );

  modport slave (
    input  reqcyc, req, reqtag, respack,
    output reqack, respcyc, resp, resptag
  );
endinterface

// File: rtl/mem_arbiter_rr.sv
// Round-robin line arbiter: N read/write clients onto one tagged Sysbus.
// One transaction in flight; the line buffer serves both directions.
module mem_arbiter_rr #(
  parameter int         NUM_CLIENTS = 2,
  parameter int         DATA_WIDTH  = 64,
  parameter int         ADDR_WIDTH  = 64,
  parameter int         LINE_BYTES  = 64,
  parameter int         TAG_WIDTH   = 13,
  parameter logic       READ_CODE   = 1'b1,
  parameter logic       WRITE_CODE  = 1'b0,
  parameter logic [3:0] MEMORY_KIND = 4'h1
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic [NUM_CLIENTS-1:0]              cli_req,
  input  logic [NUM_CLIENTS-1:0]              cli_we,
  input  logic [NUM_CLIENTS*ADDR_WIDTH-1:0]   cli_addr,
  input  logic [NUM_CLIENTS*LINE_BYTES*8-1:0] cli_wdata,
  output logic [NUM_CLIENTS-1:0]              cli_grant,
  output logic [NUM_CLIENTS-1:0]              cli_done,
  output logic [LINE_BYTES*8-1:0]             cli_rdata,
  mem_arbiter_rr_if.master                    bus,
  output logic                                err_sticky
);
  localparam int LINE_BITS = LINE_BYTES * 8;
  localparam int BEATS     = LINE_BITS / DATA_WIDTH;
  localparam int BW        = $clog2(BEATS) + 1;
  localparam int IW        = (NUM_CLIENTS > 1) ? $clog2(NUM_CLIENTS) : 1;
  localparam logic [ADDR_WIDTH-1:0] LMASK = ADDR_WIDTH'(LINE_BYTES - 1);
  localparam logic [BW-1:0]         LAST  = BW'(BEATS - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_WDATA, S_RESP, S_DONE
  } state_e;

  state_e                 state_q, state_d;
  logic [IW-1:0]          last_q, last_d;
  logic [IW-1:0]          owner_q, owner_d;
  logic                   we_q, we_d;
  logic [LINE_BITS-1:0]   line_q, line_d;
  logic [BW-1:0]          beat_q, beat_d;
  logic [LINE_BITS-1:0]   rdata_q, rdata_d;
  logic [NUM_CLIENTS-1:0] grant_q, grant_d;
  logic [NUM_CLIENTS-1:0] done_q, done_d;
  logic                   reqcyc_q, reqcyc_d;
  logic [DATA_WIDTH-1:0]  req_q, req_d;
  logic [TAG_WIDTH-1:0]   tag_q, tag_d;
  logic                   err_q, err_d;

  logic [IW-1:0] win;
  logic          ack;
  logic          tag_ok;

  assign ack    = reqcyc_q & bus.reqack;
  assign tag_ok = (bus.resptag == tag_q);

  // First requester at or after last_grant+1, wrapping once.
  always_comb begin : arb
    int   idx;
    logic found;
    idx   = 0;
    found = 1'b0;
    win   = '0;
    for (int i = 0; i < NUM_CLIENTS; i++) begin
      idx = int'(last_q) + 1 + i;
      if (idx >= NUM_CLIENTS) idx = idx - NUM_CLIENTS;
      if (!found && cli_req[idx]) begin
        win   = IW'(idx);
        found = 1'b1;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    last_d   = last_q;
    owner_d  = owner_q;
    we_d     = we_q;
    line_d   = line_q;
    beat_d   = beat_q;
    rdata_d  = rdata_q;
    grant_d  = '0;
    done_d   = '0;
    reqcyc_d = reqcyc_q;
    req_d    = req_q;
    tag_d    = tag_q;
    err_d    = err_q;

    if (bus.respcyc && state_q != S_RESP) err_d = 1'b1;

    unique case (state_q)
      S_IDLE: begin
        if (|cli_req) begin
          owner_d = win;
          we_d    = cli_we[win];
          line_d  = cli_wdata[int'(win)*LINE_BITS +: LINE_BITS];
          req_d   = DATA_WIDTH'(
            cli_addr[int'(win)*ADDR_WIDTH +: ADDR_WIDTH] & ~LMASK);
          tag_d   = TAG_WIDTH'({cli_we[win] ? WRITE_CODE : READ_CODE,
                                MEMORY_KIND, 8'(win)});
          grant_d[win] = 1'b1;
          beat_d  = '0;
          state_d = S_ADDR;
        end
      end
      S_ADDR: begin
        // Grant cycle shows reqcyc low; it rises on the next cycle.
        reqcyc_d = 1'b1;
        if (ack) begin
          beat_d = '0;
          if (we_q) begin
            state_d = S_WDATA;
            req_d   = line_q[0 +: DATA_WIDTH];
          end else begin
            state_d  = S_RESP;
            reqcyc_d = 1'b0;
          end
        end
      end
      S_WDATA: begin
        if (ack) begin
          beat_d = beat_q + BW'(1);
          if (beat_q == LAST) begin
            state_d         = S_DONE;
            reqcyc_d        = 1'b0;
            done_d[owner_q] = 1'b1;
          end else begin
            req_d = line_q[int'(beat_d)*DATA_WIDTH +: DATA_WIDTH];
          end
        end
      end
      S_RESP: begin
        if (bus.respcyc) begin
          if (tag_ok) begin
            line_d[int'(beat_q)*DATA_WIDTH +: DATA_WIDTH] = bus.resp;
            beat_d = beat_q + BW'(1);
            if (beat_q == LAST) begin
              state_d         = S_DONE;
              done_d[owner_q] = 1'b1;
              rdata_d         = line_d;
            end
          end else begin
            err_d = 1'b1;
          end
        end
      end
      S_DONE: begin
        last_d  = owner_q;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      last_q   <= IW'(NUM_CLIENTS - 1);
      owner_q  <= '0;
      we_q     <= 1'b0;
      line_q   <= '0;
      beat_q   <= '0;
      rdata_q  <= '0;
      grant_q  <= '0;
      done_q   <= '0;
      reqcyc_q <= 1'b0;
      req_q    <= '0;
      tag_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      last_q   <= last_d;
      owner_q  <= owner_d;
      we_q     <= we_d;
      line_q   <= line_d;
      beat_q   <= beat_d;
      rdata_q  <= rdata_d;
      grant_q  <= grant_d;
      done_q   <= done_d;
      reqcyc_q <= reqcyc_d;
      req_q    <= req_d;
      tag_q    <= tag_d;
      err_q    <= err_d;
    end
  end

  assign cli_grant   = grant_q;
  assign cli_done    = done_q;
  assign cli_rdata   = rdata_q;
  assign bus.reqcyc  = reqcyc_q;
  assign bus.req     = req_q;
  assign bus.reqtag  = tag_q;
  assign bus.respack = bus.respcyc;
  assign err_sticky  = err_q;
endmodule

// File: tb/tb_mem_arbiter_rr.sv
// Randomised bench for mem_arbiter_rr: the bench plays clients and memory
// and predicts grants, bus words and read lines from the arbitration rules.
module tb_mem_arbiter_rr;
  localparam int N     = 3;
  localparam int DW    = 64;
  localparam int AW    = 64;
  localparam int LB    = 64;
  localparam int TW    = 13;
  localparam int LBITS = LB * 8;
  localparam int BEATS = LBITS / DW;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic [N-1:0]       cli_req;
  logic [N-1:0]       cli_we;
  logic [N*AW-1:0]    cli_addr;
  logic [N*LBITS-1:0] cli_wdata;
  logic [N-1:0]       cli_grant;
  logic [N-1:0]       cli_done;
  logic [LBITS-1:0]   cli_rdata;
  logic               err_sticky;

  mem_arbiter_rr_if #(.DATA_WIDTH(DW), .TAG_WIDTH(TW)) bus ();

  mem_arbiter_rr #(
    .NUM_CLIENTS(N), .DATA_WIDTH(DW), .ADDR_WIDTH(AW),
    .LINE_BYTES(LB), .TAG_WIDTH(TW)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .cli_req    (cli_req),
    .cli_we     (cli_we),
    .cli_addr   (cli_addr),
    .cli_wdata  (cli_wdata),
    .cli_grant  (cli_grant),
    .cli_done   (cli_done),
    .cli_rdata  (cli_rdata),
    .bus        (bus),
    .err_sticky (err_sticky)
  );

  int checks   = 0;
  int failures = 0;

  int               m_last;
  logic             m_err;
  logic [LBITS-1:0] m_rdata;

  logic [AW-1:0]    p_addr [N];
  logic             p_we   [N];
  logic [LBITS-1:0] p_data [N];

  task automatic chk(input string tag, input logic [LBITS-1:0] got,
                     input logic [LBITS-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [N-1:0] oh(input int i);
    logic [N-1:0] v;
    v    = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  function automatic int rr_pick(input logic [N-1:0] r, input int last);
    for (int i = 1; i <= N; i++)
      if (r[(last + i) % N]) return (last + i) % N;
    return -1;
  endfunction

  task automatic drive_clients();
    for (int c = 0; c < N; c++) begin
      cli_addr[c*AW +: AW]        = p_addr[c];
      cli_we[c]                   = p_we[c];
      cli_wdata[c*LBITS +: LBITS] = p_data[c];
    end
  endtask

  task automatic new_payload(input int c);
    p_addr[c] = {$urandom, $urandom};
    p_we[c]   = 1'($urandom % 2);
    for (int i = 0; i < LBITS / 32; i++) p_data[c][i*32 +: 32] = $urandom;
  endtask

  task automatic reset_mid(input logic [N-1:0] nreq);
    reset = 1'b0;
    #1;
    chk("rst_grant", cli_grant, 0);
    chk("rst_done", cli_done, 0);
    chk("rst_rdata", cli_rdata, 0);
    chk("rst_reqcyc", bus.reqcyc, 0);
    chk("rst_req", bus.req, 0);
    chk("rst_reqtag", bus.reqtag, 0);
    chk("rst_err", err_sticky, 0);
    bus.respcyc = 1'b1;
    #1;
    chk("rst_respack", bus.respack, 1);
    bus.respcyc = 1'b0;
    m_err   = 1'b0;
    m_rdata = '0;
    m_last  = N - 1;
    cli_req = nreq;
    tick();
    reset = 1'b1;
  endtask

  // One full transaction; stimulus for the next is driven in its DONE cycle.
  task automatic run_txn(input logic [N-1:0] nreq, input int stall_word,
                         input int stall_len, input bit seq_rd,
                         input int inj_beat, input int abort_at);
    int               w, k, cyc, stalled;
    bit               ack, injected, we;
    logic [TW-1:0]    etag;
    logic [DW-1:0]    words [$];
    logic [LBITS-1:0] eline;
    w = rr_pick(cli_req, m_last);
    if (w < 0) begin
      chk("no_request", cli_req, 1);
      return;
    end
    we   = p_we[w];
    etag = {we ? 1'b0 : 1'b1, 4'h1, 8'(w)};
    words.delete();
    words.push_back(p_addr[w] & ~64'(LB - 1));
    if (we) for (int i = 0; i < BEATS; i++) words.push_back(p_data[w][i*DW +: DW]);

    tick();
    chk("grant", cli_grant, oh(w));
    chk("reqcyc_at_grant", bus.reqcyc, 0);
    new_payload(w);
    drive_clients();
    tick();
    chk("grant_pulse", cli_grant, 0);
    chk("reqcyc_rise", bus.reqcyc, 1);

    k = 0; cyc = 0; stalled = 0;
    while (k < words.size() && cyc < 200) begin
      chk("reqcyc_held", bus.reqcyc, 1);
      chk($sformatf("req_word%0d", k), bus.req, words[k]);
      chk("reqtag", bus.reqtag, etag);
      if (k == stall_word && stalled < stall_len) begin
        ack = 1'b0;
        stalled++;
      end else begin
        ack = ($urandom % 4) != 0;
      end
      bus.reqack = ack;
      tick();
      if (ack) k++;
      cyc++;
    end
    bus.reqack = 1'b0;
    chk("req_words_acked", k, words.size());

    if (!we) begin
      for (int i = 0; i < BEATS; i++)
        eline[i*DW +: DW] = seq_rd ? DW'(i) : {$urandom, $urandom};
      k = 0; cyc = 0; injected = 1'b0;
      while (k < BEATS && cyc < 200) begin
        if (k == abort_at) begin
          reset_mid(nreq);
          return;
        end
        if ($urandom % 4 == 0) begin
          bus.respcyc = 1'b0;
          tick();
        end else if (k == inj_beat && !injected) begin
          bus.respcyc = 1'b1;
          bus.resp    = {$urandom, $urandom};
          bus.resptag = etag ^ 13'h001;
          #1;
          chk("respack_bad_tag", bus.respack, 1);
          injected = 1'b1;
          m_err    = 1'b1;
          tick();
        end else begin
          bus.respcyc = 1'b1;
          bus.resp    = eline[k*DW +: DW];
          bus.resptag = etag;
          tick();
          k++;
        end
        cyc++;
      end
      bus.respcyc = 1'b0;
      chk("resp_beats", k, BEATS);
      m_rdata = eline;
    end

    chk("done", cli_done, oh(w));
    chk("rdata", cli_rdata, m_rdata);
    chk("err", err_sticky, m_err);
    chk("reqcyc_done", bus.reqcyc, 0);
    m_last  = w;
    cli_req = nreq;
    tick();
    chk("done_pulse", cli_done, 0);
    chk("grant_gap", cli_grant, 0);
  endtask

  initial begin
    cli_req     = '0;
    cli_we      = '0;
    cli_addr    = '0;
    cli_wdata   = '0;
    bus.reqack  = 1'b0;
    bus.respcyc = 1'b0;
    bus.resp    = '0;
    bus.resptag = '0;
    m_last  = N - 1;
    m_err   = 1'b0;
    m_rdata = '0;
    for (int c = 0; c < N; c++) new_payload(c);
    drive_clients();

    repeat (3) tick();
    chk("reset_grant", cli_grant, 0);
    chk("reset_done", cli_done, 0);
    chk("reset_rdata", cli_rdata, 0);
    chk("reset_reqcyc", bus.reqcyc, 0);
    chk("reset_req", bus.req, 0);
    chk("reset_reqtag", bus.reqtag, 0);
    chk("reset_err", err_sticky, 0);
    reset = 1'b1;
    tick();

    p_addr[0] = 64'h1234;
    p_we[0]   = 1'b0;
    p_addr[1] = 64'h4000;
    p_we[1]   = 1'b1;
    for (int i = 0; i < BEATS; i++) p_data[1][i*DW +: DW] = DW'(8'hA0 + i);
    drive_clients();
    cli_req = 3'b001;
    run_txn(3'b010, -1, 0, 1'b1, -1, -1);
    run_txn(3'b000, 4, 4, 1'b0, -1, -1);

    bus.respcyc = 1'b1;
    #1;
    chk("spurious_respack", bus.respack, 1);
    tick();
    bus.respcyc = 1'b0;
    m_err = 1'b1;
    chk("spurious_err", err_sticky, 1);
    chk("spurious_grant", cli_grant, 0);
    chk("spurious_reqcyc", bus.reqcyc, 0);

    p_we[0] = 1'b0;
    drive_clients();
    cli_req = 3'b001;
    run_txn(3'b001, -1, 0, 1'b0, 4, -1);

    p_we[0] = 1'b0;
    drive_clients();
    run_txn(3'b111, -1, 0, 1'b0, -1, 3);

    for (int i = 0; i < 6; i++) run_txn(3'b111, -1, 0, 1'b0, -1, -1);

    for (int i = 0; i < 30; i++)
      run_txn(3'($urandom_range(1, 7)), $urandom % 9, $urandom % 4, 1'b0,
              ($urandom % 5 == 0) ? int'($urandom % 8) : -1, -1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
